// File: rtl/hier_leaf_skid_stage_pkg.sv
// Shared types and default widths for the hierarchy leaf skid stage.
package hier_leaf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } leaf_state_e;

    localparam int unsigned LEAF_DATA_W_DFLT = 32;
    localparam int unsigned LEAF_CNT_W_DFLT  = 16;

endpackage

// File: rtl/hier_leaf_skid_stage_sat_cnt.sv
// Saturating event counter with a sticky flag raised when the count reaches all-ones.
module hier_leaf_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
        if (cnt_d == {W{1'b1}}) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/hier_leaf_skid_stage.sv
// Leaf valid/ready stage with a 2-entry skid buffer and a saturating transfer counter.
// Optional HIER_LEAF_PARITY_EN adds an even-parity bit (m_par) stored with each word.
module hier_leaf_skid_stage
    import hier_leaf_pkg::*;
#(
    parameter int unsigned DATA_W = LEAF_DATA_W_DFLT,
    parameter int unsigned CNT_W  = LEAF_CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              cnt_sat
`ifdef HIER_LEAF_PARITY_EN
    ,
    output logic              m_par
`endif
);

`ifdef HIER_LEAF_PARITY_EN
    localparam int unsigned ENT_W = DATA_W + 1;
`else
    localparam int unsigned ENT_W = DATA_W;
`endif

    leaf_state_e      state_q, state_d;
    logic [ENT_W-1:0] main_q, main_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic             m_valid_q, m_valid_d;
    logic             s_ready_q, s_ready_d;
    logic [ENT_W-1:0] entry_c;
    logic             accept_c;
    logic             drain_c;

    // Parity is captured at entry so it travels with the word through both slots.
    always_comb begin
`ifdef HIER_LEAF_PARITY_EN
        entry_c = {^s_data, s_data};
`else
        entry_c = s_data;
`endif
    end

    assign accept_c = s_valid && s_ready_q;
    assign drain_c  = m_valid_q && m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    main_d  = entry_c;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept_c && !drain_c) begin
                    skid_d  = entry_c;
                    state_d = FULL;
                end else if (drain_c && !accept_c) begin
                    state_d = EMPTY;
                end else if (accept_c && drain_c) begin
                    main_d  = entry_c;
                end
            end
            FULL: begin
                if (drain_c) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        m_valid_d = (state_d != EMPTY);
        s_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign m_valid = m_valid_q;
    assign s_ready = s_ready_q;
    assign m_data  = main_q[DATA_W-1:0];
`ifdef HIER_LEAF_PARITY_EN
    assign m_par   = main_q[DATA_W];
`endif

    hier_leaf_sat_cnt #(
        .W (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drain_c),
        .cnt (xfer_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_hier_leaf_skid_stage.sv
// Directed and seeded-random bench for hier_leaf_skid_stage (optionally with HIER_LEAF_PARITY_EN).
module tb_hier_leaf_skid_stage;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_ready;
    logic          s_ready, m_valid, cnt_sat;
    logic [DW-1:0] m_data;
    logic [15:0]   xfer_cnt;
    logic          s_ready4, m_valid4, cnt_sat4;
    logic [DW-1:0] m_data4;
    logic [3:0]    xfer_cnt4;
`ifdef HIER_LEAF_PARITY_EN
    logic          m_par, m_par4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hier_leaf_skid_stage #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .xfer_cnt(xfer_cnt), .cnt_sat(cnt_sat)
`ifdef HIER_LEAF_PARITY_EN
        , .m_par(m_par)
`endif
    );

    hier_leaf_skid_stage #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
        .xfer_cnt(xfer_cnt4), .cnt_sat(cnt_sat4)
`ifdef HIER_LEAF_PARITY_EN
        , .m_par(m_par4)
`endif
    );

    assert property (@(posedge clk) disable iff (rst)
                     (m_valid && !m_ready) |=> (m_valid && $stable(m_data)))
    else begin
        $display("FAIL stall_stable_assert m_data=%h", m_data);
        errors++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; s_valid = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
        checks++; if (cnt_sat !== 1'b0) begin errors++; $display("FAIL reset_cnt_sat got=%b exp=0", cnt_sat); end
    endtask

    task automatic test_streaming();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; s_data = 32'(i);
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_s_ready i=%0d got=%b exp=1", i, s_ready); end
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'(i)) begin
                errors++; $display("FAIL stream_out i=%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, 32'(i));
            end
        end
        s_valid = 1'b0;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b exp=0", m_valid); end
        checks++; if (xfer_cnt !== 16'd16) begin errors++; $display("FAIL stream_cnt got=%0d exp=16", xfer_cnt); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'hA;
        tick();
        s_data = 32'hB;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got=%b exp=1", s_ready); end
        tick();
        s_data = 32'hC;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", s_ready); end
        tick();
        checks++; if (s_ready !== 1'b0 || m_data !== 32'hA) begin
            errors++; $display("FAIL bp_hold got rdy=%b d=%h exp rdy=0 d=a", s_ready, m_data); end
        m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hB || s_ready !== 1'b1) begin
            errors++; $display("FAIL bp_rel_b got v=%b d=%h rdy=%b exp v=1 d=b rdy=1", m_valid, m_data, s_ready); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hC) begin
            errors++; $display("FAIL bp_rel_c got v=%b d=%h exp v=1 d=c", m_valid, m_data); end
        s_valid = 1'b0;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", m_valid); end
        checks++; if (xfer_cnt !== 16'd19) begin errors++; $display("FAIL bp_cnt got=%0d exp=19", xfer_cnt); end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        int unsigned   exp_cnt;
        int            budget;
        void'($urandom(32'd1234));
        exp_cnt = 32'(xfer_cnt);
        for (int c = 0; c < 10000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom();
            m_ready = 1'($urandom_range(0, 1));
            if (m_valid && m_ready) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
                exp_cnt++;
                checks++;
                if (m_data !== exp_d) begin errors++; $display("FAIL rand_order c=%0d got=%h exp=%h", c, m_data, exp_d); end
`ifdef HIER_LEAF_PARITY_EN
                checks++;
                if (m_par !== ^exp_d) begin errors++; $display("FAIL rand_parity c=%0d got=%b exp=%b", c, m_par, ^exp_d); end
`endif
            end
            if (s_valid && s_ready) q.push_back(s_data);
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        budget = 0;
        while (m_valid && budget < 100) begin
            exp_d = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
            exp_cnt++;
            checks++;
            if (m_data !== exp_d) begin errors++; $display("FAIL rand_drain got=%h exp=%h", m_data, exp_d); end
            tick();
            budget++;
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_drain_timeout m_valid=%b exp=0", m_valid); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_lost got_left=%0d exp=0", q.size()); end
        checks++; if (32'(xfer_cnt) != exp_cnt) begin errors++; $display("FAIL rand_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        int exp_n;
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            s_valid = (i <= 20); s_data = 32'(i);
            tick();
            exp_n = (i - 1 > 15) ? 15 : i - 1;
            checks++;
            if (xfer_cnt4 !== 4'(exp_n) || cnt_sat4 !== (i - 1 >= 15)) begin
                errors++; $display("FAIL sat i=%0d got cnt=%0d sat=%b exp cnt=%0d sat=%b", i, xfer_cnt4, cnt_sat4, exp_n, (i - 1 >= 15));
            end
        end
        s_valid = 1'b0;
        checks++; if (m_valid4 !== 1'b0) begin errors++; $display("FAIL sat_empty got=%b exp=0", m_valid4); end
    endtask

    task automatic test_midop_reset();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 32'h111; tick();
        s_data = 32'h222; tick();
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
            errors++; $display("FAIL mid_full got rdy=%b v=%b exp rdy=0 v=1", s_ready, m_valid); end
        rst = 1'b1; s_data = 32'h333;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset got v=%b rdy=%b d=%h exp v=0 rdy=1 d=0", m_valid, s_ready, m_data); end
        m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0 || xfer_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_dropped got v=%b cnt=%0d exp v=0 cnt=0", m_valid, xfer_cnt); end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_saturation();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
